traffic_phase_fsm: RTL

- Timed phase sequencer that generates the 3-bit phase code consumed by the lamp decoder, which drives the A/B red/yellow/green lamps.
- Phase encoding:
  - 0: A green / B red
  - 1: A yellow / B red
  - 2: A red / B green
  - 3: A red / B yellow
  - 4: all-red (decoder default)
- A holds green until a vehicle is sensed on B. Phase durations are counted in tick periods from a shared prescaler.

---
 rtl/traffic_phase_fsm.sv | 86 ++++++++
 1 files changed

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: tick-timed A/B phase sequencer; define ALL_RED_CLEARANCE_EN to insert all-red after each yellow
module traffic_phase_fsm #(
    parameter int GREEN_A_T = 10,
    parameter int GREEN_B_T = 6,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             sensor_b,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] tmr,
    output logic             phase_start
);
    typedef enum logic [2:0] {
        GREEN_A  = 3'd0,
        YELLOW_A = 3'd1,
        GREEN_B  = 3'd2,
        YELLOW_B = 3'd3,
        ALL_RED  = 3'd4
    } phase_e;

    logic [2:0]       state_d;
    logic [CNT_W-1:0] tmr_d;
    logic             road_b, road_b_d, start_d;

    function automatic logic [CNT_W-1:0] dur(input logic [2:0] p);
        return p == GREEN_A ? CNT_W'(GREEN_A_T - 1) :
               p == GREEN_B ? CNT_W'(GREEN_B_T - 1) :
               (p == YELLOW_A || p == YELLOW_B) ? CNT_W'(YELLOW_T - 1) :
               CNT_W'(ALL_RED_T - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ALL_RED;
            tmr         <= CNT_W'(ALL_RED_T - 1);
            road_b      <= 1'b0;
            phase_start <= 1'b0;
        end else begin
            state       <= state_d;
            tmr         <= tmr_d;
            road_b      <= road_b_d;
            phase_start <= start_d;
        end
    end

    always_comb begin
        state_d  = state;
        tmr_d    = tmr;
        road_b_d = road_b;
        start_d  = 1'b0;
        if (state > ALL_RED) begin
            state_d  = ALL_RED;
            road_b_d = 1'b0;
            start_d  = 1'b1;
            tmr_d    = dur(ALL_RED);
        end else if (tick && tmr != '0) begin
            tmr_d = tmr - 1'b1;
        end else if (tick) begin
            case (state)
                GREEN_A: state_d = sensor_b ? YELLOW_A : GREEN_A;
`ifdef ALL_RED_CLEARANCE_EN
                YELLOW_A: begin
                    state_d  = ALL_RED;
                    road_b_d = 1'b1;
                end
                YELLOW_B: begin
                    state_d  = ALL_RED;
                    road_b_d = 1'b0;
                end
`else
                YELLOW_A: state_d = GREEN_B;
                YELLOW_B: state_d = GREEN_A;
`endif
                GREEN_B: state_d = YELLOW_B;
                default: state_d = road_b ? GREEN_B : GREEN_A;
            endcase
            // holding in green A at expiry keeps tmr at zero and does not pulse
            start_d = state_d != state;
            tmr_d   = start_d ? dur(state_d) : tmr;
        end
    end
endmodule
